// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_prefetch_queue_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Generic register-array FIFO with flush; the head is read straight from storage.
module fetchq_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  parameter int  CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with redirect support feeding a valid/ready decode stream.
// Defining FETCHQ_PERF_EN adds saturating redirect / empty-stall / dropped-response counters.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch_taken,
  input  logic [XLEN-1:0]         branch_target,
  output logic                    mem_req_valid,
  output logic [XLEN-1:0]         mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [31:0]             mem_rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_instr,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0]             perf_redirects,
  output logic [31:0]             perf_empty_stall,
  output logic [31:0]             perf_dropped
`endif
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW    = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

  logic            running;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] tag_head;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [TW-1:0]   tag_count;
  logic [SW-1:0]   committed;
  logic            credit_ok;
  logic            issue;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Slots already spoken for: queued entries plus in-flight responses that will be kept.
  assign committed = SW'(occupancy) + SW'(outstanding) - SW'(drop_cnt);
  assign credit_ok = committed < SW'(DEPTH);

  assign issue         = running && !branch_taken && (outstanding < OW'(MAX_OUTSTANDING)) && credit_ok;
  assign mem_req_valid = issue;
  assign mem_req_addr  = fetch_pc;

  assign target_aligned = branch_target & ~XLEN'(3);

  assign rsp_fire = mem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_fire && (branch_taken || (drop_cnt != '0));
  assign push     = rsp_fire && !rsp_drop;

  assign out_valid = (occupancy != '0) && !branch_taken;
  assign pop       = out_valid && out_ready;

  assign push_entry.pc    = tag_head;
  assign push_entry.instr = mem_rsp_data;
  assign out_pc           = head_entry.pc;
  assign out_instr        = head_entry.instr;

  // A redirect turns every response still owed into one that must be thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      running     <= 1'b1;
      outstanding <= outstanding + OW'(issue) - OW'(rsp_fire);
      if (branch_taken) begin
        fetch_pc <= target_aligned;
        drop_cnt <= outstanding - OW'(rsp_fire);
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetchq_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (TW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetchq_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH),
    .CW    (OCC_W)
  ) u_entry_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_taken),
    .head      (head_entry),
    .count     (occupancy)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occupancy == OCC_W'(DEPTH))));

  a_tags_track: assert property (@(posedge clk) disable iff (!rst_n)
    32'(tag_count) == 32'(outstanding));

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects   <= '0;
      perf_empty_stall <= '0;
      perf_dropped     <= '0;
    end else begin
      if (branch_taken && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
      if (out_ready && !out_valid && (perf_empty_stall != '1))
        perf_empty_stall <= perf_empty_stall + 32'd1;
      if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule
